// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and the companion receiver.
//   - PAR_NONE / PAR_ODD / PAR_EVEN : parity-mode encodings for the PARITY parameter
//   - tx_state_t                    : frame-sequencing states
//   - bps_cnt()                     : clocks per bit for a given clock and baud rate
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic int bps_cnt(input int clk_freq, input int bps);
    return clk_freq / bps;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period tick generator.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   clr   : holds the counter at 0 and suppresses tick (phase restart)
//   tick  : one-cycle pulse every DIV clocks once clr is low
// TICK_AT selects where in the period the pulse lands; the receiver uses
// DIV/2-1 to sample mid-bit, the transmitter uses the default end-of-period.
module uart_baud_tick #(
  parameter int DIV     = 2,
  parameter int TICK_AT = DIV - 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] TICK_V = CNT_W'(TICK_AT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = !clr && (cnt_q == TICK_V);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter (5..9 data bits, none/odd/even parity, 1 or 2 stop bits).
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   tx_data  : payload, sent LSB first, captured when tx_valid && tx_ready
//   tx_valid : producer has a word
//   tx_ready : high only while idle; the word is taken on that edge
//   uart_txd : serial line, idle high, driven straight from a flop
//   tx_busy  : frame in progress (complement of tx_ready)
//   tx_done  : one-cycle pulse in the first idle cycle after the last stop bit
module uart_tx_cfg #(
  parameter int CLK_FREQ  = 50000000,
  parameter int UART_BPS  = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 uart_txd,
  output logic                 tx_busy,
  output logic                 tx_done
);
  import uart_pkg::*;

  localparam int BPS_CNT = bps_cnt(CLK_FREQ, UART_BPS);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (BPS_CNT < 2) begin : g_bad_bps
    $error("uart_tx_cfg: CLK_FREQ/UART_BPS must be at least 2");
  end

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [3:0]           idx_q,   idx_d;
  logic                 par_q,   par_d;
  logic                 txd_q,   txd_d;
  logic                 ready_q, ready_d;
  logic                 busy_q,  busy_d;
  logic                 done_q,  done_d;
  logic                 bit_tick;

  // Counter is held clear while idle so every accepted word starts a fresh bit period.
  uart_baud_tick #(
    .DIV (BPS_CNT)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == IDLE),
    .tick  (bit_tick)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    par_d   = par_q;
    txd_d   = txd_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (tx_valid && ready_q) begin
          state_d = START;
          shreg_d = tx_data;
          // Parity is fixed at capture because the shift register is consumed as it goes out.
          par_d   = (PARITY == PAR_ODD) ? ~(^tx_data) : ^tx_data;
          idx_d   = '0;
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (bit_tick) begin
          state_d = DATA;
          idx_d   = '0;
          txd_d   = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (idx_q == LAST_DATA) begin
            idx_d = '0;
            if (PARITY != PAR_NONE) begin
              state_d = uart_pkg::PARITY;
              txd_d   = par_q;
            end else begin
              state_d = STOP;
              txd_d   = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 4'd1;
            txd_d   = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end
      end
      uart_pkg::PARITY: begin
        if (bit_tick) begin
          state_d = STOP;
          idx_d   = '0;
          txd_d   = 1'b1;
        end
      end
      STOP: begin
        txd_d = 1'b1;
        if (bit_tick) begin
          if (idx_q == LAST_STOP) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign uart_txd = txd_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four instances with different frame formats, all at
// 10 clocks per bit, driven one at a time from a shared data bus.
//   inst 0: 8 data, no parity, 1 stop
//   inst 1: 7 data, even parity, 1 stop
//   inst 2: 7 data, odd parity, 2 stop
//   inst 3: 9 data, no parity, 2 stop
module tb_uart_tx_cfg;

  localparam int BPS = 10;

  logic       clk;
  logic       rst_n;
  logic [8:0] tx_data;
  logic [3:0] valid;
  wire  [3:0] ready;
  wire  [3:0] txd;
  wire  [3:0] busy;
  wire  [3:0] done;

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_cfg #(.CLK_FREQ(1000), .UART_BPS(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[7:0]), .tx_valid(valid[0]),
    .tx_ready(ready[0]), .uart_txd(txd[0]), .tx_busy(busy[0]), .tx_done(done[0]));

  uart_tx_cfg #(.CLK_FREQ(1000), .UART_BPS(100), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_b (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[6:0]), .tx_valid(valid[1]),
    .tx_ready(ready[1]), .uart_txd(txd[1]), .tx_busy(busy[1]), .tx_done(done[1]));

  uart_tx_cfg #(.CLK_FREQ(1000), .UART_BPS(100), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_c (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[6:0]), .tx_valid(valid[2]),
    .tx_ready(ready[2]), .uart_txd(txd[2]), .tx_busy(busy[2]), .tx_done(done[2]));

  uart_tx_cfg #(.CLK_FREQ(1000), .UART_BPS(100), .DATA_BITS(9), .PARITY(0), .STOP_BITS(2)) u_d (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid[3]),
    .tx_ready(ready[3]), .uart_txd(txd[3]), .tx_busy(busy[3]), .tx_done(done[3]));

  function automatic int nb_of(input int i);
    case (i)
      0:       return 8;
      1, 2:    return 7;
      default: return 9;
    endcase
  endfunction

  function automatic int par_of(input int i);
    case (i)
      1:       return 2;
      2:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int ns_of(input int i);
    return (i >= 2) ? 2 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one word on instance i and checks every cycle of the frame against a
  // bit list built from the frame rules. hold keeps tx_valid up through the
  // frame and loads nxt in the done cycle; immediate requires instant acceptance.
  task automatic send(input int i, input logic [8:0] d, input bit hold,
                      input logic [8:0] nxt, input bit scramble, input bit poke,
                      input bit immediate);
    bit   exp_bits[$];
    logic p;
    int   nb, pr, ns, w, n;
    nb = nb_of(i);
    pr = par_of(i);
    ns = ns_of(i);
    p  = 1'b0;
    exp_bits.push_back(1'b0);
    for (int k = 0; k < nb; k++) begin
      exp_bits.push_back(d[k]);
      p = p ^ d[k];
    end
    if (pr == 2) exp_bits.push_back(p);
    else if (pr == 1) exp_bits.push_back(~p);
    for (int k = 0; k < ns; k++) exp_bits.push_back(1'b1);

    tx_data  = d;
    valid[i] = 1'b1;
    w = 0;
    while (!ready[i] && w < 1000) begin
      step();
      w++;
    end
    if (immediate) chk($sformatf("gap%0d", i), w, 0);
    if (!ready[i]) begin
      chk($sformatf("accept_timeout%0d", i), 0, 1);
      valid[i] = 1'b0;
      return;
    end
    step();
    if (!hold) valid[i] = 1'b0;
    if (scramble) tx_data = 9'($urandom);

    n = exp_bits.size() * BPS;
    for (int c = 0; c < n; c++) begin
      chk($sformatf("txd%0d_c%0d", i, c), txd[i], exp_bits[c / BPS]);
      chk($sformatf("ready%0d_c%0d", i, c), ready[i], 0);
      chk($sformatf("busy%0d_c%0d", i, c), busy[i], 1);
      chk($sformatf("done%0d_c%0d", i, c), done[i], 0);
      if (poke && !hold && c == 3 * BPS)     valid[i] = 1'b1;
      if (poke && !hold && c == 3 * BPS + 1) valid[i] = 1'b0;
      step();
    end
    chk($sformatf("done_pulse%0d", i), done[i], 1);
    chk($sformatf("ready_end%0d", i), ready[i], 1);
    chk($sformatf("busy_end%0d", i), busy[i], 0);
    chk($sformatf("txd_end%0d", i), txd[i], 1);
    if (hold) begin
      tx_data = nxt;
      return;
    end
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("idle_done%0d", i), done[i], 0);
      chk($sformatf("idle_ready%0d", i), ready[i], 1);
      chk($sformatf("idle_txd%0d", i), txd[i], 1);
    end
  endtask

  initial begin
    int          i;
    logic [8:0]  d, nx;
    bit          h, sc, po;

    rst_n   = 1'b0;
    valid   = '0;
    tx_data = '0;
    repeat (3) step();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_txd%0d", k), txd[k], 1);
      chk($sformatf("rst_ready%0d", k), ready[k], 1);
      chk($sformatf("rst_busy%0d", k), busy[k], 0);
      chk($sformatf("rst_done%0d", k), done[k], 0);
    end
    rst_n = 1'b1;
    step();

    // Directed frames
    send(0, 9'h0A5, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0);
    send(1, 9'h055, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0);
    send(2, 9'h055, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0);
    send(3, 9'h1FF, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0);

    // Back-to-back with tx_valid held
    send(0, 9'h011, 1'b1, 9'h022, 1'b0, 1'b0, 1'b0);
    send(0, 9'h022, 1'b0, 9'h000, 1'b0, 1'b0, 1'b1);

    // Data changed after accept and a stray valid pulse while busy
    send(1, 9'h03C, 1'b0, 9'h000, 1'b1, 1'b1, 1'b0);

    // Reset during data bit 3
    tx_data  = 9'h0F3;
    valid[0] = 1'b1;
    step();
    valid[0] = 1'b0;
    repeat (BPS * 4 + 3) step();
    chk("pre_rst_busy", busy[0], 1);
    rst_n = 1'b0;
    #1;
    chk("arst_txd", txd[0], 1);
    chk("arst_ready", ready[0], 1);
    chk("arst_busy", busy[0], 0);
    chk("arst_done", done[0], 0);
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 2 * BPS; c++) begin
      step();
      chk("post_rst_done", done[0], 0);
      chk("post_rst_txd", txd[0], 1);
    end
    send(0, 9'h0C3, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0);

    // Randomized frames across all formats
    repeat (24) begin
      i  = int'($urandom_range(0, 3));
      d  = 9'($urandom);
      nx = 9'($urandom);
      h  = 1'($urandom_range(0, 1));
      sc = 1'($urandom_range(0, 1));
      po = 1'($urandom_range(0, 1));
      if (h) begin
        send(i, d, 1'b1, nx, sc, 1'b0, 1'b0);
        send(i, nx, 1'b0, 9'h000, sc, po, 1'b1);
      end else begin
        send(i, d, 1'b0, 9'h000, sc, po, 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
